// File: rtl/qspi_seq_ctrl.sv
// Quad-SPI transaction sequencer: cmd/addr/dummy/data phases on a 4-bit bus,
// drives the receive shifter's capture controls and returns its read word.
module qspi_seq_ctrl #(
   parameter int ADDR_W = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [7:0]        cmd_i,
   input  logic              has_addr_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        dummy_i,
   input  logic              rw_i,
   input  logic [5:0]        size_i,
   input  logic              lsb_i,
   input  logic [31:0]       wdata_i,
   input  logic [31:0]       rdata_i,
   output logic              ready_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              cs_no,
   output logic              sck_en_o,
   output logic [3:0]        sdo_o,
   output logic [3:0]        sdo_oe_o,
   output logic              rx_busy_o,
   output logic [5:0]        rx_size_o,
   output logic              rx_lsb_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY,
      S_WDATA, S_RPRIME, S_RDATA, S_DONE
   } state_e;

   localparam logic [5:0] ADDR_LAST = 6'(ADDR_W / 4 - 1);

   state_e            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [7:0]        cmd_q, cmd_d;
   logic              has_addr_q, has_addr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        dummy_q, dummy_d;
   logic              rw_q, rw_d;
   logic [5:0]        size_q, size_d;
   logic              lsb_q, lsb_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              done_q, done_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              cs_n_q, cs_n_d;
   logic              sck_en_q, sck_en_d;
   logic [3:0]        sdo_q, sdo_d;
   logic [3:0]        sdo_oe_q, sdo_oe_d;
   logic              rx_busy_q, rx_busy_d;
   logic [5:0]        rx_size_q, rx_size_d;
   logic              rx_lsb_q, rx_lsb_d;

   state_e            data_st, dum_st, adr_st;
   logic [5:0]        data_cnt, dum_cnt, adr_cnt;
   logic [5:0]        widx;

   // request latch; size is rounded down to nibbles and clamped to a word
   always_comb begin
      cmd_d      = cmd_q;
      has_addr_d = has_addr_q;
      addr_d     = addr_q;
      dummy_d    = dummy_q;
      rw_d       = rw_q;
      size_d     = size_q;
      lsb_d      = lsb_q;
      wdata_d    = wdata_q;
      if (state_q == S_IDLE && start_i) begin
         cmd_d      = cmd_i;
         has_addr_d = has_addr_i;
         addr_d     = addr_i;
         dummy_d    = dummy_i;
         rw_d       = rw_i;
         size_d     = (size_i > 6'd32) ? 6'd32 : {size_i[5:2], 2'b00};
         lsb_d      = lsb_i;
         wdata_d    = wdata_i;
      end
   end

   // successor phase of each optional stage, with counter reload value
   always_comb begin
      data_st  = S_DONE;
      data_cnt = '0;
      if (size_d != '0) begin
         if (rw_d) begin
            data_st  = S_WDATA;
            data_cnt = {2'b00, size_d[5:2]} - 6'd1;
         end else begin
            data_st = S_RPRIME;
         end
      end
      dum_st  = data_st;
      dum_cnt = data_cnt;
      if (dummy_d != '0) begin
         dum_st  = S_DUMMY;
         dum_cnt = {2'b00, dummy_d} - 6'd1;
      end
      adr_st  = dum_st;
      adr_cnt = dum_cnt;
      if (has_addr_d) begin
         adr_st  = S_ADDR;
         adr_cnt = ADDR_LAST;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 6'd1 : cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CMD;
               cnt_d   = 6'd1;
            end
         end
         S_CMD: begin
            if (cnt_q == '0) begin
               state_d = adr_st;
               cnt_d   = adr_cnt;
            end
         end
         S_ADDR: begin
            if (cnt_q == '0) begin
               state_d = dum_st;
               cnt_d   = dum_cnt;
            end
         end
         S_DUMMY: begin
            if (cnt_q == '0) begin
               state_d = data_st;
               cnt_d   = data_cnt;
            end
         end
         S_WDATA, S_RDATA: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_RPRIME: begin
            state_d = S_RDATA;
            cnt_d   = {2'b00, size_d[5:2]} - 6'd1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // outputs are decoded from the next state so they register in step with it
   always_comb begin
      cs_n_d    = 1'b1;
      sck_en_d  = 1'b0;
      sdo_d     = '0;
      sdo_oe_d  = '0;
      rx_busy_d = 1'b0;
      rx_size_d = '0;
      rx_lsb_d  = 1'b0;
      widx      = lsb_d ? {2'b00, size_d[5:2]} - 6'd1 - cnt_d : cnt_d;
      if (state_d != S_IDLE) begin
         rx_size_d = size_d;
         rx_lsb_d  = lsb_d;
      end
      unique case (state_d)
         S_CMD: begin
            cs_n_d   = 1'b0;
            sck_en_d = 1'b1;
            sdo_oe_d = 4'hF;
            sdo_d    = cnt_d[0] ? cmd_d[7:4] : cmd_d[3:0];
         end
         S_ADDR: begin
            cs_n_d   = 1'b0;
            sck_en_d = 1'b1;
            sdo_oe_d = 4'hF;
            sdo_d    = 4'(32'(addr_d) >> {cnt_d, 2'b00});
         end
         S_DUMMY: begin
            cs_n_d   = 1'b0;
            sck_en_d = 1'b1;
         end
         S_WDATA: begin
            cs_n_d   = 1'b0;
            sck_en_d = 1'b1;
            sdo_oe_d = 4'hF;
            sdo_d    = 4'(wdata_d >> {widx, 2'b00});
         end
         S_RPRIME: begin
            cs_n_d    = 1'b0;
            rx_busy_d = 1'b1;
         end
         S_RDATA: begin
            cs_n_d    = 1'b0;
            sck_en_d  = 1'b1;
            rx_busy_d = 1'b1;
         end
         S_IDLE, S_DONE: begin
         end
      endcase
      done_d  = (state_q == S_DONE);
      rdata_d = (state_q == S_DONE && !rw_q) ? rdata_i : rdata_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         has_addr_q <= 1'b0;
         addr_q     <= '0;
         dummy_q    <= '0;
         rw_q       <= 1'b0;
         size_q     <= '0;
         lsb_q      <= 1'b0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         rdata_q    <= '0;
         cs_n_q     <= 1'b1;
         sck_en_q   <= 1'b0;
         sdo_q      <= '0;
         sdo_oe_q   <= '0;
         rx_busy_q  <= 1'b0;
         rx_size_q  <= '0;
         rx_lsb_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         has_addr_q <= has_addr_d;
         addr_q     <= addr_d;
         dummy_q    <= dummy_d;
         rw_q       <= rw_d;
         size_q     <= size_d;
         lsb_q      <= lsb_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         cs_n_q     <= cs_n_d;
         sck_en_q   <= sck_en_d;
         sdo_q      <= sdo_d;
         sdo_oe_q   <= sdo_oe_d;
         rx_busy_q  <= rx_busy_d;
         rx_size_q  <= rx_size_d;
         rx_lsb_q   <= rx_lsb_d;
      end
   end

   assign ready_o   = (state_q == S_IDLE);
   assign done_o    = done_q;
   assign rdata_o   = rdata_q;
   assign cs_no     = cs_n_q;
   assign sck_en_o  = sck_en_q;
   assign sdo_o     = sdo_q;
   assign sdo_oe_o  = sdo_oe_q;
   assign rx_busy_o = rx_busy_q;
   assign rx_size_o = rx_size_q;
   assign rx_lsb_o  = rx_lsb_q;

endmodule
